// File: rtl/merge_pkg.sv
// Shared types and helpers for the merge-sort upper layer merge stage.
package merge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      MERGE,
      DRAIN_A,
      DRAIN_B,
      DONE
   } merge_state_t;

   // Counter must hold 0..n inclusive, so size for n+1 values.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/merge_select_unit_min_select.sv
// Unsigned compare-and-select of two chain heads; ties resolve to A for a stable merge.
module min_select #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  sel_a,
   output logic [DATA_WIDTH-1:0] min_val
);

   assign sel_a   = (a <= b);
   assign min_val = sel_a ? a : b;

endmodule

// File: rtl/merge_select_unit.sv
// Merges two ascending shift chains (A, B) into one ascending stream of 2*TRAIN_LENGTH
// elements, popping the consumed chain head each cycle.
module merge_select_unit
   import merge_pkg::*;
#(
   parameter int TRAIN_LENGTH = 3,
   parameter int DATA_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] a_data,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic                  shift_a,
   output logic                  shift_b,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  busy,
   output logic                  done
);

   localparam int            CW   = cnt_width(TRAIN_LENGTH);
   localparam logic [CW-1:0] LAST = CW'(TRAIN_LENGTH);

   merge_state_t          state_q, state_d;
   logic [CW-1:0]         cnt_a_q, cnt_a_d;
   logic [CW-1:0]         cnt_b_q, cnt_b_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  done_q, done_d;
   logic                  shift_a_c, shift_b_c;
   logic                  sel_a;
   logic [DATA_WIDTH-1:0] min_val;

   min_select #(.DATA_WIDTH(DATA_WIDTH)) u_min_select (
      .a       (a_data),
      .b       (b_data),
      .sel_a   (sel_a),
      .min_val (min_val)
   );

   always_comb begin
      state_d     = state_q;
      cnt_a_d     = cnt_a_q;
      cnt_b_d     = cnt_b_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
      shift_a_c   = 1'b0;
      shift_b_c   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = MERGE;
               cnt_a_d = '0;
               cnt_b_d = '0;
            end
         end
         MERGE: begin
            out_valid_d = 1'b1;
            out_data_d  = min_val;
            if (sel_a) begin
               shift_a_c = 1'b1;
               cnt_a_d   = cnt_a_q + CW'(1);
               if (cnt_a_d == LAST) state_d = DRAIN_B;
            end else begin
               shift_b_c = 1'b1;
               cnt_b_d   = cnt_b_q + CW'(1);
               if (cnt_b_d == LAST) state_d = DRAIN_A;
            end
         end
         // Drains re-check the count so an exhausted chain is never popped.
         DRAIN_A: begin
            if (cnt_a_q != LAST) begin
               shift_a_c   = 1'b1;
               out_valid_d = 1'b1;
               out_data_d  = a_data;
               cnt_a_d     = cnt_a_q + CW'(1);
               if (cnt_a_d == LAST) state_d = DONE;
            end else begin
               state_d = DONE;
            end
         end
         DRAIN_B: begin
            if (cnt_b_q != LAST) begin
               shift_b_c   = 1'b1;
               out_valid_d = 1'b1;
               out_data_d  = b_data;
               cnt_b_d     = cnt_b_q + CW'(1);
               if (cnt_b_d == LAST) state_d = DONE;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_a_q     <= '0;
         cnt_b_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_a_q     <= cnt_a_d;
         cnt_b_q     <= cnt_b_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end

   assign shift_a   = shift_a_c;
   assign shift_b   = shift_b_c;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;

endmodule

// File: tb/tb_merge_select_unit.sv
// Self-checking bench: chain heads modelled as queues, expected stream from a sorted key list.
module tb_merge_select_unit;

   localparam int TL = 3;
   typedef logic [7:0] vec_t [3];

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a_data = '0, b_data = '0;
   logic       shift_a, shift_b, out_valid, busy, done;
   logic [7:0] out_data;

   logic       start1 = 1'b0;
   logic [7:0] a1 = '0, b1 = '0;
   logic       shift_a1, shift_b1, out_valid1, busy1, done1;
   logic [7:0] out_data1;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] aq[$];
   logic [7:0] bq[$];

   always #5 clk = ~clk;

   merge_select_unit #(.TRAIN_LENGTH(TL), .DATA_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .start(start), .a_data(a_data), .b_data(b_data),
      .shift_a(shift_a), .shift_b(shift_b), .out_data(out_data), .out_valid(out_valid),
      .busy(busy), .done(done)
   );

   merge_select_unit #(.TRAIN_LENGTH(1), .DATA_WIDTH(8)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .a_data(a1), .b_data(b1),
      .shift_a(shift_a1), .shift_b(shift_b1), .out_data(out_data1), .out_valid(out_valid1),
      .busy(busy1), .done(done1)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Upstream chains: pop the head on shift, present the new head from the same edge.
   always @(posedge clk) begin
      if (shift_a) begin
         chk("underflow_a", 32'(aq.size() > 0), 1);
         if (aq.size() > 0) void'(aq.pop_front());
      end
      if (shift_b) begin
         chk("underflow_b", 32'(bq.size() > 0), 1);
         if (bq.size() > 0) void'(bq.pop_front());
      end
      a_data <= (aq.size() > 0) ? aq[0] : 8'd0;
      b_data <= (bq.size() > 0) ? bq[0] : 8'd0;
   end

   function automatic vec_t sort3(input vec_t v);
      vec_t r = v;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2 - i; j++)
            if (r[j] > r[j+1]) begin
               logic [7:0] t = r[j];
               r[j] = r[j+1];
               r[j+1] = t;
            end
      return r;
   endfunction

   // rst_at >= 0: pull reset after that many outputs; start_at >= 0: extra start pulse at that cycle.
   task automatic run(input string nm, input vec_t av, input vec_t bv,
                      input int rst_at, input int start_at);
      int  keys[$];
      int  n = 0;
      int  ns = 0;
      bit  fin = 0;
      aq.delete();
      bq.delete();
      for (int i = 0; i < TL; i++) begin
         aq.push_back(av[i]);
         bq.push_back(bv[i]);
         keys.push_back(int'(av[i]) * 2);
         keys.push_back(int'(bv[i]) * 2 + 1);
      end
      keys.sort();
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk({nm, "_busy"}, 32'(busy), 1);
      for (int cyc = 0; cyc < 20 && !fin; cyc++) begin
         if (shift_a || shift_b) begin
            chk({nm, "_onehot"}, 32'(shift_a & shift_b), 0);
            chk({nm, "_src"}, 32'(shift_b), (ns < keys.size()) ? 32'(keys[ns] & 1) : 32'd2);
            ns++;
         end
         if (out_valid) begin
            chk({nm, "_data"}, 32'(out_data), (n < keys.size()) ? 32'(keys[n] >> 1) : 32'd999);
            n++;
         end
         if (done) begin
            chk({nm, "_done_cyc"}, 32'(cyc), 32'(2 * TL + 1));
            chk({nm, "_n_out"}, 32'(n), 32'(2 * TL));
            chk({nm, "_valid_at_done"}, 32'(out_valid), 0);
            chk({nm, "_hold"}, 32'(out_data), 32'(keys[2*TL-1] >> 1));
            fin = 1;
         end
         if (!fin && rst_at >= 0 && n == rst_at) begin
            reset = 1'b0;
            #1;
            chk({nm, "_rst_valid"}, 32'(out_valid), 0);
            chk({nm, "_rst_data"}, 32'(out_data), 0);
            chk({nm, "_rst_busy"}, 32'(busy), 0);
            chk({nm, "_rst_shift"}, 32'({shift_a, shift_b, done}), 0);
            @(negedge clk);
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            return;
         end
         start = (cyc == start_at);
         if (!fin) @(negedge clk);
      end
      start = 1'b0;
      if (!fin) chk({nm, "_timeout"}, 0, 1);
      @(negedge clk);
      chk({nm, "_done_pulse"}, 32'({done, busy, out_valid}), 0);
   endtask

   initial begin
      vec_t ra, rb;
      #1;
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_flags", 32'({busy, done, shift_a, shift_b}), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      run("interleave", '{8'd2, 8'd5, 8'd9}, '{8'd1, 8'd6, 8'd7}, -1, -1);
      run("a_first",    '{8'd1, 8'd2, 8'd3}, '{8'd4, 8'd5, 8'd6}, -1, -1);
      run("ties",       '{8'd3, 8'd3, 8'd255}, '{8'd3, 8'd3, 8'd255}, -1, -1);
      run("midreset",   '{8'd2, 8'd5, 8'd9}, '{8'd1, 8'd6, 8'd7}, 2, -1);
      run("post_reset", '{8'd10, 8'd20, 8'd30}, '{8'd15, 8'd25, 8'd35}, -1, -1);
      run("start_busy", '{8'd4, 8'd8, 8'd12}, '{8'd6, 8'd8, 8'd10}, -1, 3);

      for (int it = 0; it < 20; it++) begin
         int lim = (it % 2) ? 7 : 255;
         for (int i = 0; i < 3; i++) begin
            ra[i] = 8'($urandom_range(0, lim));
            rb[i] = 8'($urandom_range(0, lim));
         end
         run("rand", sort3(ra), sort3(rb), -1, (it % 5 == 0) ? int'($urandom_range(0, 5)) : -1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // TRAIN_LENGTH=1 instance: tie goes to A, then B drains.
      a1 = 8'd7;
      b1 = 8'd7;
      start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      chk("tl1_c0_shift", 32'({shift_a1, shift_b1}), 32'b10);
      chk("tl1_c0_valid", 32'(out_valid1), 0);
      @(negedge clk);
      chk("tl1_c1_out", 32'({out_valid1, out_data1}), 32'({1'b1, 8'd7}));
      chk("tl1_c1_shift", 32'({shift_a1, shift_b1}), 32'b01);
      @(negedge clk);
      chk("tl1_c2_out", 32'({out_valid1, out_data1}), 32'({1'b1, 8'd7}));
      chk("tl1_c2_flags", 32'({shift_a1, shift_b1, done1}), 0);
      @(negedge clk);
      chk("tl1_c3_done", 32'({done1, out_valid1, busy1}), 32'b100);
      @(negedge clk);
      chk("tl1_c4_idle", 32'({done1, busy1}), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
